truncator_arbiter: RTL
======================

// Module: truncator_arbiter
// PURPOSE
//  Shares one psum truncation stage among NUM_REQ requesters, e.g. PE psum channels draining to the GLB.
//  - Each requester offers a 2*DATA_WIDTH accumulated psum on a valid/ready port.
//  - A round-robin arbiter grants one requester per cycle.
//  - The winning psum is cut to DATA_WIDTH bits at a configured bit offset: out = in[sel +: DATA_WIDTH].
//  - The result is registered and presented on a single valid/ready output, tagged with the requester id.
// PARAMETERS
//  DATA_WIDTH  16                    output word width; request words are 2*DATA_WIDTH
//  NUM_REQ     4                     number of requesters, >= 2
//  SEL_WIDTH   $clog2(DATA_WIDTH)    offset field is SEL_WIDTH+1 bits
//  ID_WIDTH    $clog2(NUM_REQ)       width of out_id
// PORTS
//  clk        in   1                       clock, all logic on rising edge
//  reset      in   1                       synchronous reset, active-high
//  cfg_load   in   1                       load cfg_sel into the offset register
//  cfg_sel    in   SEL_WIDTH+1             truncation bit offset
//  req_valid  in   NUM_REQ                 per-requester psum valid
//  req_data   in   NUM_REQ*2*DATA_WIDTH    psums; requester k at [k*2*DW +: 2*DW]
//  req_ready  out  NUM_REQ                 one-hot grant; handshake when valid&ready
//  out_valid  out  1                       output word valid
//  out_data   out  DATA_WIDTH              truncated psum
//  out_id     out  ID_WIDTH                index of the source requester
//  out_ready  in   1                       downstream accepts output
//  sel_q      out  SEL_WIDTH+1             current offset register, for debug/config readback
// BEHAVIOUR
//  - Reset (sync, active-high) clears all state: sel_q=0, rr_ptr=0, out_valid=0, out_data=0, out_id=0.
//    req_ready=0 during the reset cycle.
//    Reset during a pending output drops that word; it is not replayed.
//  - Offset register:
//    - On cfg_load, sel_q <= min(cfg_sel, DATA_WIDTH); values above DATA_WIDTH clamp to DATA_WIDTH,
//      so no out-of-range bits are ever read.
//    - The new value applies to grants from the next cycle onward.
//    - A word already in the output register is unaffected.
//    - cfg_load in the same cycle as a grant: that grant uses the old sel_q.
//  - Output slot:
//    - One-entry register; free = !out_valid | out_ready.
//  - Arbitration (combinational):
//    - Only when the slot is free.
//    - Scan req_valid starting at index rr_ptr, wrapping NUM_REQ-1 -> 0.
//    - The first asserted index k gets req_ready[k]=1; all other bits are 0.
//    - If the slot is not free or no request is pending, req_ready=0.
//    - req_ready never depends on req_valid of the granted index alone: no ready-before-valid deadlock, no comb loop to out_ready other than free.
//  - Grant cycle N (req_valid[k] & req_ready[k]):
//    - At edge N: out_data <= req_data[k][sel_q +: DATA_WIDTH], out_id <= k, out_valid <= 1.
//    - At the same edge: rr_ptr <= (k+1) mod NUM_REQ.
//    - Latency is 1 cycle from handshake to out_valid.
//    - Back-to-back: with out_ready held high, one word per cycle, 100% throughput.
//  - Output hold:
//    - While out_valid & !out_ready, out_data and out_id are stable, and there are no grants.
//    - Drain with no new grant: out_valid <= 0.
//    - Drain and grant in the same cycle: the register loads the new word and out_valid stays 1.
//  - No request is ever lost: a requester holds valid and data until its handshake. The arbiter does not check this; it is the requester's protocol obligation.
//  - Fairness: with all requesters valid continuously, grants rotate 0,1,...,NUM_REQ-1,0,...
//    - Any valid requester is served within NUM_REQ grants.
//  - rr_ptr advances only on a grant; idle cycles do not move it.
// TESTING
//  1. Reset then idle: reset high 2 cycles -> out_valid=0, req_ready=0, sel_q=0, out_data=0, out_id=0.
//  2. Single request, DW=16:
//     cfg_sel=4 loaded; req_data[2]=32'h0001_2340, req_valid=4'b0100, out_ready=1
//     -> req_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=16'h1234, out_id=2.
//  3. Round-robin: req_valid=4'b1111 held, out_ready=1
//     -> grants 0,1,2,3,0 on consecutive cycles, out_id follows one cycle later.
//  4. Backpressure: word pending with out_ready=0 for 3 cycles
//     -> req_ready=0 and out_data stable for those cycles; out_ready=1 drains the word and the next grant loads in the same cycle.
//  5. Config edges:
//     - cfg_sel=20 -> sel_q=16, out_data=in[31:16].
//     - cfg_load coinciding with a grant -> that word uses the old offset, the next uses the new.
//  6. Reset mid-operation: out_valid=1, rr_ptr=3, reset pulse
//     -> out_valid=0, rr_ptr=0; with all requesters valid, the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/truncator_arbiter.sv
// rtl/truncator_arbiter.sv - round-robin arbiter sharing one psum truncation stage
module truncator_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = $clog2(DATA_WIDTH),
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_load,
  input  logic [SEL_WIDTH:0]            cfg_sel,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          out_ready,
  output logic [SEL_WIDTH:0]            sel_q
);

  localparam logic [ID_WIDTH:0]  NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [SEL_WIDTH:0] SEL_MAX   = (SEL_WIDTH+1)'(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] words [NUM_REQ];
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     grant_id;
  logic [ID_WIDTH:0]       scan_idx;
  logic                    found;
  logic                    free;
  logic                    grant;
  logic [2*DATA_WIDTH-1:0] grant_word;
  logic [DATA_WIDTH-1:0]   trunc_data;
  logic [SEL_WIDTH:0]      sel_clamped;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign words[k] = req_data[k*2*DATA_WIDTH +: 2*DATA_WIDTH];
  end

  assign free = !out_valid || out_ready;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (!found && req_valid[scan_idx[ID_WIDTH-1:0]]) begin
        found    = 1'b1;
        grant_id = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  assign grant = found && free && !reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_id] = 1'b1;
  end

  assign grant_word  = words[grant_id];
  assign trunc_data  = DATA_WIDTH'(grant_word >> sel_q);
  assign sel_clamped = (cfg_sel > SEL_MAX) ? SEL_MAX : cfg_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q     <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      if (cfg_load) sel_q <= sel_clamped;
      if (grant) begin
        out_data  <= trunc_data;
        out_id    <= grant_id;
        out_valid <= 1'b1;
        rr_ptr    <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
